seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
Multi-cycle unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor. Division is the inverse of the multiply path, and each iteration reuses the ripple add/subtract datapath style, running in subtract mode as a trial subtraction. It sits beside the adder/subtractor blocks as the arithmetic unit's divide path. It has a start/busy/done handshake and produces one quotient bit per clock.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
dividend  input  WIDTH  unsigned dividend, sampled with accepted start
divisor  input  WIDTH  unsigned divisor, sampled with accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when results become valid
quotient  output  WIDTH  result quotient, held until next accepted start
remainder  output  WIDTH  result remainder, held until next accepted start
div_by_zero  output  1  set with done when divisor was 0; held like results

Behaviour:
- Reset (async assert, sync deassert by design of the driver): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal regs and counter cleared. Assertion mid-operation aborts the division. No done pulse follows.
- States: IDLE, CALC, FINISH.
- IDLE or FINISH with start=1: latch dividend into Q reg, divisor into D reg, R reg=0, count=WIDTH, and clear div_by_zero.
  - divisor!=0: go to CALC, busy=1.
  - divisor==0: go to FINISH directly with quotient=all ones, remainder=dividend, div_by_zero=1. done=1 in the next cycle.
- CALC, once per cycle:
  - {R,Q} shifted left 1; trial = {R,Q[msb]} - {0,D}, computed at WIDTH+1 bits as A + ~B + 1 (subtract mode of add/sub unit).
  - Carry-out=1 (no borrow): R = trial low WIDTH bits and new Q lsb = 1.
  - Carry-out=0: R = shifted value (restore) and new Q lsb = 0.
  - count decrements; after the WIDTH-th iteration go to FINISH.
- FINISH entry cycle: quotient<=Q, remainder<=R, done=1 for exactly one cycle, busy=0.
  - State stays FINISH (results held) until a start arrives. FINISH behaves as IDLE for acceptance.
- Latency: start accepted at edge 0; done high after edge WIDTH+1 (5 cycles for WIDTH=4). Divide-by-zero: done after edge 1.
- start while busy: ignored, no queueing. Operand inputs changing during CALC: no effect.
- start in the same cycle as done: accepted (back-to-back). done drops and busy rises next cycle.
- Arithmetic is unsigned only. Invariant: quotient*divisor + remainder == dividend, remainder < divisor.

Decomposition:
- Shared package div_pkg: state encoding constants (IDLE, CALC, FINISH), default WIDTH, counter width = clog2(WIDTH+1).
- One sub-module: addsub_unit (WIDTH+1-bit ripple adder/subtractor, mode input XORs B and drives carry-in, exposes carry-out). Instantiated once in subtract mode.
- FSM, shift registers and counter stay in the top module.

Test Plan:
- Reset then start with 13/4 -> done exactly 5 cycles later; quotient=3, remainder=1, div_by_zero=0; busy high for cycles 1-4.
- 15/1 -> quotient=15, remainder=0. 15/15 -> quotient=1, remainder=0. 7/9 -> quotient=0, remainder=7.
- 9/0 -> done 1 cycle after start; quotient=15, remainder=9, div_by_zero=1; next 6/3 clears flag -> quotient=2, remainder=0.
- Start 12/5, then pulse start with 14/2 at cycle 2 -> second start ignored; result quotient=2, remainder=2.
- Start 11/3, assert rst_n=0 at cycle 3 -> all outputs 0 immediately, no done; after release 11/3 -> quotient=3, remainder=2.
- Exhaustive sweep of all 256 operand pairs with back-to-back starts on done -> every result matches the reference model and div-by-zero rule, with no lost or duplicate done pulses.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// the default operand width and the iteration counter width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // The counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// Ripple-carry adder/subtractor: mode=1 inverts b and injects a carry-in,
// so sum = a - b and carry_out=1 means no borrow.
module addsub_unit #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] b_eff;
  logic             cy;

  assign b_eff = b ^ {WIDTH{mode}};

  always_comb begin
    sum = '0;
    cy  = mode;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ cy;
      cy     = (a[i] & b_eff[i]) | (cy & (a[i] ^ b_eff[i]));
    end
    carry_out = cy;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider producing one quotient bit per clock through a
// trial subtraction on a shared add/sub datapath.
//
//   state  | meaning
//   IDLE   | no result yet, waiting for start
//   CALC   | shift/trial-subtract iterations, count runs WIDTH..1
//   FINISH | results pending (pend) or published and held; accepts start
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] q_reg, r_reg, d_reg;
  logic [CW-1:0]    count;
  logic             pend, dz_pend;
  logic             accept, publish, last_iter;
  logic [WIDTH:0]   trial_a, trial_b, trial;
  logic             no_borrow;
  logic             unused_bits;

  assign accept    = start && ((state == IDLE) || ((state == FINISH) && !pend));
  assign publish   = (state == FINISH) && pend;
  assign last_iter = (state == CALC) && (count == CW'(1));

  assign trial_a = {r_reg, q_reg[WIDTH-1]};
  assign trial_b = {1'b0, d_reg};

  addsub_unit #(.WIDTH(WIDTH + 1)) u_sub (
    .a         (trial_a),
    .b         (trial_b),
    .mode      (1'b1),
    .sum       (trial),
    .carry_out (no_borrow)
  );

  // Because R < D on every iteration, a successful trial fits in WIDTH bits.
  assign unused_bits = trial[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, FINISH: if (accept) state_next = (divisor == '0) ? FINISH : CALC;
      CALC:         if (last_iter) state_next = FINISH;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      pend        <= 1'b0;
      dz_pend     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= publish;
      if (accept) begin
        d_reg       <= divisor;
        count       <= CW'(WIDTH);
        div_by_zero <= 1'b0;
        busy        <= (divisor != '0);
        // Divide-by-zero skips CALC and publishes the defined fallback result.
        if (divisor == '0) begin
          q_reg   <= '1;
          r_reg   <= dividend;
          pend    <= 1'b1;
          dz_pend <= 1'b1;
        end else begin
          q_reg   <= dividend;
          r_reg   <= '0;
          pend    <= 1'b0;
          dz_pend <= 1'b0;
        end
      end else if (state == CALC) begin
        q_reg <= {q_reg[WIDTH-2:0], no_borrow};
        r_reg <= no_borrow ? trial[WIDTH-1:0] : trial_a[WIDTH-1:0];
        count <= count - CW'(1);
        if (last_iter) pend <= 1'b1;
      end else if (publish) begin
        quotient    <= q_reg;
        remainder   <= r_reg;
        div_by_zero <= dz_pend;
        pend        <= 1'b0;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks of seq_restoring_divider against plain
// integer division, including latency, divide-by-zero and handshake rules.
module tb_seq_restoring_divider;

  localparam int W = 4;
  localparam int TIMEOUT = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;
  logic busy_log [0:63];

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? (1 << W) - 1 : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic kick(input int a, input int b);
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Called just after the accepting edge; lat = edges until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    @(negedge clk);
    busy_log[0] = busy;
    check("done_low_after_start", done, 0);
    while (done !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat < 64) busy_log[lat] = busy;
    end
    check("done_seen", done, 1);
  endtask

  task automatic check_res(input string tag, input int a, input int b, input int lat);
    check({tag, "_lat"}, lat, (b == 0) ? 1 : W + 1);
    check({tag, "_q"}, quotient, ref_q(a, b));
    check({tag, "_r"}, remainder, ref_r(a, b));
    check({tag, "_dz"}, div_by_zero, (b == 0) ? 1 : 0);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic run(input string tag, input int a, input int b);
    int lat;
    kick(a, b);
    wait_done(lat);
    check_res(tag, a, b, lat);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int a, b, off, idx, na, nb;
    bit saw_done;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_by_zero, 0);
    rst_n = 1'b1;

    run("d13_4", 13, 4);
    for (int i = 1; i <= 4; i++) check("busy_window", busy_log[i], 1);

    run("d15_1", 15, 1);
    run("d15_15", 15, 15);
    run("d7_9", 7, 9);
    run("d9_0", 9, 0);
    run("d6_3", 6, 3);

    // A start pulse while busy must be ignored.
    kick(12, 5);
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check_res("ignore_busy_start", 12, 5, lat + 2);

    // Reset mid-division aborts it with no done pulse.
    kick(11, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dz", div_by_zero, 0);
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run("d11_3_after_rst", 11, 3);

    // Exhaustive sweep, back-to-back starts issued in the done cycle.
    off = $urandom_range(0, 255);
    a = off / 16;
    b = off % 16;
    kick(a, b);
    for (int k = 0; k < 256; k++) begin
      wait_done(lat);
      check_res("sweep", a, b, lat);
      if (k < 255) begin
        idx = (k + 1 + off) % 256;
        na = idx / 16;
        nb = idx % 16;
        dividend = W'(na);
        divisor  = W'(nb);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, (nb != 0) ? 1 : 0);
        a = na;
        b = nb;
      end
    end
    @(negedge clk);
    check("sweep_last_done_pulse", done, 0);

    // Random operands with random idle gaps.
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run("rand", $urandom_range(0, 15), $urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
